// File: rtl/multi_debounce.sv
// multi_debounce: N-channel button/switch debouncer.
// Each channel has a 2-flop synchroniser, a tick-qualified stability counter and
// registered one-cycle rise/fall pulses. A shared prescaler generates the tick so
// per-channel counters stay narrow.
// Optional auto-repeat: define MULTI_DEBOUNCE_REPEAT_EN. Without it, repeat_pulse is tied to 0.
// The auto-repeat output is named repeat_pulse because "repeat" is a reserved word.
module multi_debounce #(
    parameter int   CHANNELS      = 4,
    parameter int   TICK_DIV      = 1000,
    parameter int   STABLE_TICKS  = 16,
    parameter logic INIT_STATE    = 1'b0,
    parameter int   REPEAT_DELAY  = 500,
    parameter int   REPEAT_PERIOD = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] state,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] repeat_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_TICKS - 1);

    logic [PW-1:0]       presc;
    logic                tick;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CW-1:0]       cnt [CHANNELS];
    logic [CHANNELS-1:0] flip;

    // With TICK_DIV=1 the prescaler sits at 0 and tick is permanently high.
    assign tick = (presc == PRESC_LAST);

    // Shared prescaler: counts 0..TICK_DIV-1 and wraps.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses <= so every flop samples pre-edge values.
        if (!rst_n)     presc <= '0;
        else if (tick)  presc <= '0;
        else            presc <= presc + 1'b1;
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= {CHANNELS{INIT_STATE}};
            sync2 <= {CHANNELS{INIT_STATE}};
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // A channel flips on the tick that completes its stability window.
    always_comb begin
        // NOTE: default first so every path assigns flip and no latch is inferred.
        flip = '0;
        for (int i = 0; i < CHANNELS; i++)
            flip[i] = (sync2[i] != state[i]) && tick && (cnt[i] == CNT_LAST);
    end

    // Per-channel stability counters, debounced state and edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= {CHANNELS{INIT_STATE}};
            rise  <= '0;
            fall  <= '0;
            // NOTE: the counter array is reset so a partial count never survives reset.
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                rise[i] <= flip[i] &  sync2[i];
                fall[i] <= flip[i] & ~sync2[i];
                if (sync2[i] == state[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (flip[i]) begin
                        state[i] <= sync2[i];
                        cnt[i]   <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rcnt [CHANNELS];
    logic [CHANNELS-1:0] armed;   // first repeat already issued since the rise

    // Auto-repeat: first pulse REPEAT_DELAY ticks after rise, then every REPEAT_PERIOD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            repeat_pulse <= '0;
            armed        <= '0;
            for (int i = 0; i < CHANNELS; i++) rcnt[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                repeat_pulse[i] <= 1'b0;
                // A flip while high is the fall edge, so repeat never shares a cycle with it.
                if (!state[i] || flip[i]) begin
                    rcnt[i]  <= '0;
                    armed[i] <= 1'b0;
                end else if (tick) begin
                    if (rcnt[i] == (armed[i] ? PERIOD_LAST : DELAY_LAST)) begin
                        repeat_pulse[i] <= 1'b1;
                        rcnt[i]         <= '0;
                        armed[i]        <= 1'b1;
                    end else begin
                        rcnt[i] <= rcnt[i] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign repeat_pulse = '0;
`endif

endmodule
